ifetch_bus_ctrl: RTL and testbench
==================================

Name: ifetch_bus_ctrl

Overview:
- Fetch sequencer between the PC stage's address FIFO and instruction FIFO.
- Pops fetch addresses from the address FIFO, issues in-order reads on the instruction bus with a req/gnt/rvalid handshake, and buffers returned words.
- Drains buffered words into the instruction FIFO.
- Enforces an outstanding-request credit limit and discards stale responses on a jump flush.

Parameters:
- MAX_OUTSTANDING, 2: max words popped but not yet written to the inst FIFO (range 1..8); also the depth of the internal response buffer.
- ADDR_W, 32: fetch address width.
- DATA_W, 32: instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush_i  in  1  jump flush; high while the PC stage holds the addr FIFO in reset
- addr_fifo_empty_i  in  1  addr FIFO empty
- addr_fifo_r_i  in  ADDR_W  addr FIFO read data; valid the cycle after addr_fifo_ren_o
- addr_fifo_ren_o  out  1  addr FIFO pop
- bus_req_o  out  1  bus read request
- bus_addr_o  out  ADDR_W  bus read address
- bus_gnt_i  in  1  request accepted this cycle
- bus_rvalid_i  in  1  read data valid; responses return in request order
- bus_rdata_i  in  DATA_W  read data
- inst_fifo_full_i  in  1  inst FIFO full
- inst_fifo_wen_o  out  1  inst FIFO push
- inst_fifo_w_o  out  DATA_W  inst FIFO write data
- busy_o  out  1  any request in LOAD/REQ, in flight, buffered, or pending drop

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; every output 0; all counters cleared; response buffer emptied.
- State machine:
  - IDLE: addr_fifo_ren_o=1 when eligible; next state LOAD.
  - LOAD: latch addr_fifo_r_i into addr_q; next state REQ. If flush_i=1, drop the latched address and go to IDLE.
  - REQ: bus_req_o=1, bus_addr_o=addr_q, held stable until bus_gnt_i.
    - On gnt: the request becomes in-flight. If eligible in the same cycle, assert addr_fifo_ren_o and go to LOAD; otherwise go to IDLE.
- Eligible = ~flush_i & ~addr_fifo_empty_i & (res_cnt < MAX_OUTSTANDING) & drop_cnt_next==0 not required.
  - res_cnt counts the entry in LOAD/REQ, live in-flight requests, and buffered words.
  - In the REQ-with-gnt cycle, the granted entry stays counted.
- bus_req_o is never retracted before gnt, even under flush.
- Sustained throughput: 1 request per 2 cycles. Latency from pop to bus_req_o: 2 cycles.
- Counters:
  - res_cnt: +1 on pop; -1 on inst_fifo_wen_o; cleared on flush (except as below).
  - live_cnt (in-flight, not dropped): +1 on gnt, -1 on a kept rvalid.
  - drop_cnt: responses to discard.
- Responses:
  - bus_rvalid_i with drop_cnt>0: discard the word, drop_cnt-1.
  - Otherwise: write the word to the buffer tail and decrement live_cnt.
  - Buffer overflow cannot occur given credits. An rvalid with live_cnt=0 and drop_cnt=0 is ignored.
- Drain:
  - inst_fifo_wen_o = buffer non-empty & ~inst_fifo_full_i & ~flush_i.
  - inst_fifo_w_o = buffer head.
  - rvalid at cycle T gives wen at T+1 at the earliest (no bypass).
- Flush (every cycle flush_i=1):
  - Buffer emptied; no pops; no pushes.
  - drop_cnt += live_cnt + (REQ & gnt ? 1 : 0); live_cnt=0; res_cnt=0.
  - A rvalid in a flush cycle is discarded and is not added to drop_cnt.
  - If in REQ without gnt, the request stays pending. Its later gnt adds 1 to drop_cnt (flagged by a dropped-REQ bit) and does not count in res_cnt.
- After flush_i falls: pops resume immediately. Stale responses are filtered by drop_cnt, which is correct because responses are in order.
- Widths: res_cnt, live_cnt and drop_cnt are $clog2(MAX_OUTSTANDING+1)+1 bits.

Optional Feature:
- IFETCH_PERF_CNT_EN defined:
  - Adds outputs perf_req_stall_o[31:0] (cycles with bus_req_o & ~bus_gnt_i) and perf_fifo_stall_o[31:0] (cycles with buffer non-empty & inst_fifo_full_i).
  - Both saturate at 32'hFFFFFFFF, clear only on rst, and are unaffected by flush.
- Undefined: these ports and counters do not exist.

Test Plan:
- Addr FIFO holds 0x0,0x4,0x8; gnt tied 1; rvalid 1 cycle after gnt with data 0x13,0x93,0x113 -> bus_addr_o sequence 0x0,0x4,0x8; inst FIFO receives 0x13,0x93,0x113 in order; busy_o returns to 0.
- MAX_OUTSTANDING=2, gnt=1, rvalid withheld -> exactly 2 gnts, then addr_fifo_ren_o stays 0 until one word drains.
- bus_gnt_i held 0 for 5 cycles in REQ -> bus_req_o and bus_addr_o=0x10 stable for all 5 cycles; perf_req_stall_o=5 with IFETCH_PERF_CNT_EN.
- 2 requests in flight, flush_i pulsed 1 cycle, new addr 0x100 popped -> both old responses discarded; first inst FIFO write is the 0x100 data.
- Flush while in REQ without gnt; gnt arrives 3 cycles later -> that response is dropped; drop_cnt returns to 0.
- inst_fifo_full_i=1 for 4 cycles with 2 buffered words -> no pops (credit exhausted), no writes; both words written on consecutive cycles after full clears.

Source files
------------

// File: rtl/ifetch_bus_ctrl_if.sv
// Fetch-side handshake bundle: address FIFO pop, instruction bus read channel,
// and instruction FIFO push. The controller uses the master modport.
interface ifetch_bus_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              addr_fifo_empty_i;
    logic [ADDR_W-1:0] addr_fifo_r_i;
    logic              addr_fifo_ren_o;
    logic              bus_req_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic              bus_gnt_i;
    logic              bus_rvalid_i;
    logic [DATA_W-1:0] bus_rdata_i;
    logic              inst_fifo_full_i;
    logic              inst_fifo_wen_o;
    logic [DATA_W-1:0] inst_fifo_w_o;

    modport master (
        input  addr_fifo_empty_i, addr_fifo_r_i, bus_gnt_i, bus_rvalid_i,
               bus_rdata_i, inst_fifo_full_i,
        output addr_fifo_ren_o, bus_req_o, bus_addr_o, inst_fifo_wen_o,
               inst_fifo_w_o
    );

    modport slave (
        output addr_fifo_empty_i, addr_fifo_r_i, bus_gnt_i, bus_rvalid_i,
               bus_rdata_i, inst_fifo_full_i,
        input  addr_fifo_ren_o, bus_req_o, bus_addr_o, inst_fifo_wen_o,
               inst_fifo_w_o
    );
endinterface

// File: rtl/ifetch_bus_ctrl.sv
// Instruction fetch sequencer: addr FIFO -> in-order bus reads -> response buffer -> inst FIFO.
// Define IFETCH_PERF_CNT_EN to add the saturating perf_req_stall_o / perf_fifo_stall_o counters.
module ifetch_bus_ctrl #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    ifetch_bus_ctrl_if.master   bus,
    output logic                busy_o
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_req_stall_o,
    output logic [31:0]         perf_fifo_stall_o
`endif
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1) + 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {IDLE, LOAD, REQ} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CW-1:0]     res_cnt, live_cnt, drop_cnt, buf_cnt;
    logic              req_dropped_q;
    logic [DATA_W-1:0] buf_mem [MAX_OUTSTANDING];
    logic [PW-1:0]     rd_ptr, wr_ptr;

    logic eligible, pop, granted, buf_empty, push_inst;
    logic rv_drop, rv_keep, rv_flush_consume;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign buf_empty = (buf_cnt == '0);
    assign granted   = (state_q == REQ) && bus.bus_gnt_i;
    assign eligible  = ~rst & ~flush_i & ~bus.addr_fifo_empty_i & (res_cnt < MAX_C);
    assign push_inst = ~buf_empty & ~bus.inst_fifo_full_i & ~flush_i;

    // Responses return in order, so the oldest outstanding ones are the stale ones.
    assign rv_drop          = bus.bus_rvalid_i & ~flush_i & (drop_cnt != '0);
    assign rv_keep          = bus.bus_rvalid_i & ~flush_i & (drop_cnt == '0) & (live_cnt != '0);
    assign rv_flush_consume = bus.bus_rvalid_i & flush_i & ((drop_cnt != '0) | (live_cnt != '0));

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (eligible) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = flush_i ? IDLE : REQ;
            REQ: begin
                if (bus.bus_gnt_i) begin
                    pop     = eligible;
                    state_d = eligible ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == LOAD) addr_q <= bus.addr_fifo_r_i;
        end
    end

    // A request flushed while waiting for gnt stays on the bus; its grant is
    // then accounted as one more response to discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_cnt       <= '0;
            live_cnt      <= '0;
            drop_cnt      <= '0;
            req_dropped_q <= 1'b0;
        end else if (flush_i) begin
            res_cnt       <= '0;
            live_cnt      <= '0;
            drop_cnt      <= drop_cnt + live_cnt + CW'(granted) - CW'(rv_flush_consume);
            req_dropped_q <= (state_q == REQ) && !bus.bus_gnt_i;
        end else begin
            res_cnt  <= res_cnt + CW'(pop) - CW'(push_inst);
            live_cnt <= live_cnt + CW'(granted & ~req_dropped_q) - CW'(rv_keep);
            drop_cnt <= drop_cnt + CW'(granted & req_dropped_q) - CW'(rv_drop);
            if (granted) req_dropped_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            buf_cnt <= '0;
        end else if (flush_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            buf_cnt <= '0;
        end else begin
            if (rv_keep)   wr_ptr <= ptr_inc(wr_ptr);
            if (push_inst) rd_ptr <= ptr_inc(rd_ptr);
            buf_cnt <= buf_cnt + CW'(rv_keep) - CW'(push_inst);
        end
    end

    always_ff @(posedge clk) begin
        if (rv_keep) buf_mem[wr_ptr] <= bus.bus_rdata_i;
    end

    assign bus.addr_fifo_ren_o = pop;
    assign bus.bus_req_o       = (state_q == REQ);
    assign bus.bus_addr_o      = (state_q == REQ) ? addr_q : '0;
    assign bus.inst_fifo_wen_o = push_inst;
    assign bus.inst_fifo_w_o   = buf_empty ? '0 : buf_mem[rd_ptr];
    assign busy_o = (state_q != IDLE) | (live_cnt != '0) | (drop_cnt != '0) | ~buf_empty;

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_req_stall_o  <= '0;
            perf_fifo_stall_o <= '0;
        end else begin
            if (bus.bus_req_o && !bus.bus_gnt_i && !(&perf_req_stall_o))
                perf_req_stall_o <= perf_req_stall_o + 32'd1;
            if (!buf_empty && bus.inst_fifo_full_i && !(&perf_fifo_stall_o))
                perf_fifo_stall_o <= perf_fifo_stall_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ifetch_bus_ctrl.sv
// Scoreboard bench for ifetch_bus_ctrl: expected bus addresses and inst FIFO
// words are queued by the stimulus and popped by a negedge monitor.
module tb_ifetch_bus_ctrl;
    logic clk, rst, flush, busy;
    logic gnt_en, rv_en, full;
    logic [31:0] afr, resp_data;
    logic resp_avail;
    int addr_cnt;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_rs, perf_fs;
`endif

    int n_checks = 0, n_errors = 0;
    int cnt_gnt = 0, cnt_ren = 0, cnt_wen = 0;
    logic [31:0] exp_bus[$], exp_inst[$], addr_model[$], resp_q[$];

    ifetch_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

    assign ifc.addr_fifo_empty_i = (addr_cnt == 0);
    assign ifc.addr_fifo_r_i     = afr;
    assign ifc.bus_gnt_i         = gnt_en;
    assign ifc.bus_rvalid_i      = rv_en & resp_avail;
    assign ifc.bus_rdata_i       = resp_data;
    assign ifc.inst_fifo_full_i  = full;

    ifetch_bus_ctrl #(.MAX_OUTSTANDING(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .bus(ifc), .busy_o(busy)
`ifdef IFETCH_PERF_CNT_EN
        , .perf_req_stall_o(perf_rs), .perf_fifo_stall_o(perf_fs)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] dat(input logic [31:0] a);
        return (a << 5) | 32'h13;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_addr(input logic [31:0] a, input bit keep);
        addr_model.push_back(a);
        addr_cnt = addr_cnt + 1;
        exp_bus.push_back(a);
        if (keep) exp_inst.push_back(dat(a));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || addr_cnt != 0 || exp_inst.size() != 0 || exp_bus.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_inst_pending", 32'(exp_inst.size()), 32'd0);
    endtask

    // Bus/addr-FIFO model and scoreboard monitor; samples at negedge, updates after posedge.
    initial begin
        logic f_ren, f_gnt, f_rv;
        logic [31:0] g_addr;
        afr = '0; resp_data = '0; resp_avail = 1'b0;
        forever begin
            @(negedge clk);
            f_ren  = ifc.addr_fifo_ren_o;
            f_gnt  = ifc.bus_req_o & ifc.bus_gnt_i;
            f_rv   = ifc.bus_rvalid_i;
            g_addr = ifc.bus_addr_o;
            if (f_ren) cnt_ren++;
            if (f_gnt) begin
                cnt_gnt++;
                if (exp_bus.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL bus_unexpected: got addr %h expected no request", g_addr);
                end else check("bus_addr", g_addr, exp_bus.pop_front());
            end
            if (ifc.inst_fifo_wen_o) begin
                cnt_wen++;
                if (exp_inst.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL inst_unexpected: got word %h expected no write", ifc.inst_fifo_w_o);
                end else check("inst_data", ifc.inst_fifo_w_o, exp_inst.pop_front());
            end
            @(posedge clk);
            #1;
            if (f_ren && addr_model.size() > 0) begin
                afr = addr_model.pop_front();
                addr_cnt = addr_cnt - 1;
            end
            if (f_rv && resp_q.size() > 0) void'(resp_q.pop_front());
            if (f_gnt) resp_q.push_back(dat(g_addr));
            resp_avail = (resp_q.size() > 0);
            resp_data  = (resp_q.size() > 0) ? resp_q[0] : 32'h0;
        end
    end

    initial begin
        int base_gnt, base_ren, base_wen, n;
        logic [31:0] perf0;
        rst = 1; flush = 0; gnt_en = 1; rv_en = 1; full = 0; addr_cnt = 0;
        perf0 = '0;
        push_addr(32'h0, 1'b1);
        repeat (2) tick();
        @(negedge clk);
        check("rst_ren", 32'(ifc.addr_fifo_ren_o), 32'd0);
        check("rst_req", 32'(ifc.bus_req_o), 32'd0);
        check("rst_addr", ifc.bus_addr_o, 32'd0);
        check("rst_wen", 32'(ifc.inst_fifo_wen_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 0;

        // Basic stream of three fetches
        push_addr(32'h4, 1'b1);
        push_addr(32'h8, 1'b1);
        wait_idle(100);

        // Credit limit with responses withheld
        rv_en = 0;
        base_gnt = cnt_gnt; base_ren = cnt_ren;
        push_addr(32'h20, 1'b1);
        push_addr(32'h24, 1'b1);
        push_addr(32'h28, 1'b1);
        repeat (12) tick();
        check("credit_gnts", 32'(cnt_gnt - base_gnt), 32'd2);
        check("credit_pops", 32'(cnt_ren - base_ren), 32'd2);
        check("credit_addr_left", 32'(addr_cnt), 32'd1);
        rv_en = 1;
        wait_idle(100);

        // Grant stall: request held stable for 5 cycles
`ifdef IFETCH_PERF_CNT_EN
        perf0 = perf_rs;
`endif
        gnt_en = 0;
        push_addr(32'h10, 1'b1);
        n = 0;
        while (!ifc.bus_req_o && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req", 32'(ifc.bus_req_o), 32'd1);
            check("stall_addr", ifc.bus_addr_o, 32'h10);
        end
        tick();
        gnt_en = 1;
        wait_idle(100);
`ifdef IFETCH_PERF_CNT_EN
        check("perf_req_stall", perf_rs - perf0, 32'd5);
`endif

        // Flush with two requests in flight
        rv_en = 0;
        base_gnt = cnt_gnt;
        push_addr(32'h40, 1'b0);
        push_addr(32'h44, 1'b0);
        repeat (8) tick();
        check("flush_inflight_gnts", 32'(cnt_gnt - base_gnt), 32'd2);
        flush = 1;
        tick();
        flush = 0;
        rv_en = 1;
        push_addr(32'h100, 1'b1);
        wait_idle(100);

        // Flush while REQ waits for gnt; late grant must be discarded
        gnt_en = 0;
        base_wen = cnt_wen;
        push_addr(32'h50, 1'b0);
        n = 0;
        while (!ifc.bus_req_o && n < 20) begin
            tick();
            n++;
        end
        flush = 1;
        tick();
        flush = 0;
        repeat (2) tick();
        check("flush_req_held", 32'(ifc.bus_req_o), 32'd1);
        gnt_en = 1;
        wait_idle(100);
        check("flush_req_no_write", 32'(cnt_wen - base_wen), 32'd0);
        push_addr(32'h54, 1'b1);
        wait_idle(100);

        // Inst FIFO full with two buffered words
        full = 1;
        push_addr(32'h60, 1'b1);
        push_addr(32'h64, 1'b1);
        push_addr(32'h68, 1'b1);
        repeat (10) tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_no_pop", 32'(ifc.addr_fifo_ren_o), 32'd0);
            check("full_no_write", 32'(ifc.inst_fifo_wen_o), 32'd0);
        end
        tick();
        full = 0;
        @(negedge clk);
        check("drain_first", 32'(ifc.inst_fifo_wen_o), 32'd1);
        @(negedge clk);
        check("drain_second", 32'(ifc.inst_fifo_wen_o), 32'd1);
        wait_idle(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
